// File: rtl/p3_execute.sv
// p3_execute: execute stage of the 16-bit SIMPLE multi-cycle datapath.
// Captures one instruction per rising clockp3 edge while running. It computes the
// ALU result and SZCV flags, resolves branches, drives the OUT port and holds the
// sticky halt. The ready side is implicit: the stage accepts an instruction on
// every edge while in RUN and accepts nothing once HALTED. Only reset leaves
// HALTED.
module p3_execute #(
    parameter int WIDTH = 16
) (
    input  logic             clockp3,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu1,
    input  logic [WIDTH-1:0] alu2,
    input  logic [3:0]       opcode,
    input  logic             isimm,
    input  logic [3:0]       shamt,
    input  logic             writereg,
    input  logic [2:0]       regaddress,
    input  logic [1:0]       memwrite,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] storedata,
    input  logic             isbranch,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] pcin,
    input  logic [WIDTH-1:0] inport,
    output logic [WIDTH-1:0] aluresult,
    output logic             writeregout,
    output logic [2:0]       regaddressout,
    output logic [1:0]       memwriteout,
    output logic [WIDTH-1:0] addressout,
    output logic [WIDTH-1:0] storedataout,
    output logic [3:0]       flags,
    output logic             branchtaken,
    output logic [WIDTH-1:0] branchtarget,
    output logic [WIDTH-1:0] outport,
    output logic             outvalid,
    output logic             haltout,
    output logic             fsmstate
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t state, state_next;

    // Arithmetic and shift datapath. Each shift is widened by one bit so the
    // extra bit holds the last bit shifted out, and that bit becomes C.
    logic [WIDTH:0]        add_w;
    logic [WIDTH:0]        sub_w;
    logic [WIDTH-1:0]      sub_x;
    logic [WIDTH-1:0]      sub_y;
    logic                  add_v;
    logic                  sub_v;
    logic [WIDTH:0]        sll_w;
    logic [WIDTH:0]        srl_w;
    logic signed [WIDTH:0] sra_in;
    logic [WIDTH:0]        sra_w;
    logic [WIDTH-1:0]      rol_r;
    logic [WIDTH-1:0]      target;
    logic                  halting;

    // Register form computes Rb - Rs and immediate form computes Rs - imm.
    assign sub_x  = isimm ? alu1 : alu2;
    assign sub_y  = isimm ? alu2 : alu1;
    assign add_w  = {1'b0, alu1} + {1'b0, alu2};
    assign sub_w  = {1'b0, sub_x} - {1'b0, sub_y};
    assign add_v  = (alu1[15] == alu2[15]) && (add_w[15] != alu1[15]);
    assign sub_v  = (sub_x[15] != sub_y[15]) && (sub_w[15] != sub_x[15]);
    assign sll_w  = {1'b0, alu2} << shamt;
    assign srl_w  = {alu2, 1'b0} >> shamt;
    assign sra_in = {alu2, 1'b0};
    assign sra_w  = sra_in >>> shamt;
    // alu2 >> 16 is zero, so shamt = 0 leaves the operand unchanged.
    assign rol_r  = (alu2 << shamt) | (alu2 >> (5'd16 - {1'b0, shamt}));
    assign target = pcin + address;
    assign halting = !isbranch && (opcode == 4'b1111);
    assign fsmstate = (state == HALTED);

    logic [WIDTH-1:0] res_n;
    logic             c_n;
    logic             v_n;
    logic             upd_flags;
    logic             out_wr;
    logic             taken;
    logic [3:0]       flags_n;

    // State register.
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Next state: HLT parks the stage until reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halting) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Output logic: next result, flags and branch decision for the current inputs.
    always_comb begin
        res_n     = '0;
        c_n       = 1'b0;
        v_n       = 1'b0;
        upd_flags = 1'b0;
        out_wr    = 1'b0;
        case (cond)
            3'd0:    taken = flags[2];
            3'd1:    taken = flags[3] ^ flags[0];
            3'd2:    taken = flags[2] | (flags[3] ^ flags[0]);
            3'd3:    taken = !flags[2];
            3'd4:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (isbranch) begin
            res_n = target;
        end else begin
            case (opcode)
                4'b0000: begin res_n = add_w[15:0]; c_n = add_w[16]; v_n = add_v; upd_flags = 1'b1; end
                4'b0001,
                4'b0101: begin res_n = sub_w[15:0]; c_n = sub_w[16]; v_n = sub_v; upd_flags = 1'b1; end
                4'b0010: begin res_n = alu1 & alu2; upd_flags = 1'b1; end
                4'b0011: begin res_n = alu1 | alu2; upd_flags = 1'b1; end
                4'b0100: begin res_n = alu1 ^ alu2; upd_flags = 1'b1; end
                4'b0110: begin res_n = alu1; upd_flags = 1'b1; end
                4'b1000: begin res_n = sll_w[15:0]; c_n = sll_w[16]; upd_flags = 1'b1; end
                4'b1001: begin res_n = rol_r; upd_flags = 1'b1; end
                4'b1010: begin res_n = srl_w[16:1]; c_n = srl_w[0]; upd_flags = 1'b1; end
                4'b1011: begin res_n = sra_w[16:1]; c_n = sra_w[0]; upd_flags = 1'b1; end
                4'b1100: res_n = inport;
                4'b1101: out_wr = 1'b1;
                default: res_n = '0;
            endcase
        end
        flags_n = upd_flags ? {res_n[15], (res_n == 16'd0), c_n, v_n} : flags;
    end

    // Pipeline registers: capture while running, freeze once halted.
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) begin
            aluresult     <= '0;
            writeregout   <= 1'b0;
            regaddressout <= '0;
            memwriteout   <= '0;
            addressout    <= '0;
            storedataout  <= '0;
            flags         <= '0;
            branchtaken   <= 1'b0;
            branchtarget  <= '0;
            outport       <= '0;
            outvalid      <= 1'b0;
            haltout       <= 1'b0;
        end else if (state == RUN) begin
            aluresult     <= res_n;
            writeregout   <= writereg && !isbranch && !halting;
            regaddressout <= regaddress;
            memwriteout   <= (isbranch || halting) ? 2'b00 : memwrite;
            addressout    <= address;
            storedataout  <= storedata;
            flags         <= flags_n;
            branchtaken   <= isbranch && taken;
            branchtarget  <= target;
            if (out_wr) outport <= alu1;
            outvalid      <= out_wr;
            haltout       <= halting;
        end
    end

endmodule

// File: tb/tb_p3_execute.sv
// tb_p3_execute: table vectors, hand sequences and random stimulus for p3_execute,
// checked against an arithmetic reference model of the execute stage.
module tb_p3_execute;

  logic        clockp3 = 1'b0;
  logic        reset;
  logic [15:0] alu1, alu2, address, storedata, pcin, inport;
  logic [3:0]  opcode, shamt;
  logic        isimm, writereg, isbranch;
  logic [2:0]  regaddress, cond;
  logic [1:0]  memwrite;

  logic [15:0] aluresult, addressout, storedataout, branchtarget, outport;
  logic        writeregout, branchtaken, outvalid, haltout, fsmstate;
  logic [2:0]  regaddressout;
  logic [1:0]  memwriteout;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_bad = 0;

  // expected outputs held by the reference model
  logic [15:0] e_aluresult, e_addr, e_sd, e_btgt, e_outport;
  logic        e_wr, e_bt, e_outvalid, e_halt;
  logic [2:0]  e_ra;
  logic [1:0]  e_mw;
  logic [3:0]  e_flags;

  typedef struct {
    logic [3:0]  op;
    logic        imm;
    logic [3:0]  sh;
    logic [15:0] a1;
    logic [15:0] a2;
    logic        br;
    logic [2:0]  cnd;
    logic [15:0] pc;
    logic [15:0] adr;
    logic [15:0] exp_res;
    logic [3:0]  exp_flags;
    logic        exp_bt;
  } vec_t;

  vec_t tbl[12];

  p3_execute dut (
    .clockp3(clockp3), .reset(reset), .alu1(alu1), .alu2(alu2), .opcode(opcode),
    .isimm(isimm), .shamt(shamt), .writereg(writereg), .regaddress(regaddress),
    .memwrite(memwrite), .address(address), .storedata(storedata), .isbranch(isbranch),
    .cond(cond), .pcin(pcin), .inport(inport), .aluresult(aluresult),
    .writeregout(writeregout), .regaddressout(regaddressout), .memwriteout(memwriteout),
    .addressout(addressout), .storedataout(storedataout), .flags(flags),
    .branchtaken(branchtaken), .branchtarget(branchtarget), .outport(outport),
    .outvalid(outvalid), .haltout(haltout), .fsmstate(fsmstate)
  );

  // clock / reset block
  always #5 clockp3 = ~clockp3;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_aluresult = 0; e_addr = 0; e_sd = 0; e_btgt = 0; e_outport = 0;
    e_wr = 0; e_bt = 0; e_outvalid = 0; e_halt = 0; e_ra = 0; e_mw = 0; e_flags = 0;
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // reference model: one captured instruction, plain integer arithmetic
  task automatic model_step();
    int a, b, n, r, s, c, v, x, y;
    bit upd, tk;
    if (e_halt) return;
    a = alu1; b = alu2; n = shamt; r = 0; c = 0; v = 0; upd = 0;
    e_btgt = 16'((int'(pcin) + int'(address)) % 65536);
    e_ra = regaddress; e_addr = address; e_sd = storedata;
    e_wr = writereg; e_mw = memwrite; e_outvalid = 0; e_bt = 0;
    if (isbranch) begin
      case (cond)
        0: tk = e_flags[2];
        1: tk = e_flags[3] ^ e_flags[0];
        2: tk = e_flags[2] | (e_flags[3] ^ e_flags[0]);
        3: tk = !e_flags[2];
        4: tk = 1;
        default: tk = 0;
      endcase
      e_bt = tk; e_aluresult = e_btgt; e_wr = 0; e_mw = 0;
    end else begin
      case (opcode)
        0: begin s = a + b; r = s % 65536; c = (s >= 65536);
             s = sgn(a) + sgn(b); v = (s > 32767 || s < -32768); upd = 1; end
        1, 5: begin
             x = isimm ? a : b; y = isimm ? b : a;
             r = (x - y + 65536) % 65536; c = (x < y);
             s = sgn(x) - sgn(y); v = (s > 32767 || s < -32768); upd = 1; end
        2: begin r = a & b; upd = 1; end
        3: begin r = a | b; upd = 1; end
        4: begin r = a ^ b; upd = 1; end
        6: begin r = a; upd = 1; end
        8: begin s = b * (1 << n); r = s % 65536; c = (s / 65536) % 2; upd = 1; end
        9: begin s = b * (1 << n); r = s % 65536 + s / 65536; upd = 1; end
        10: begin r = b / (1 << n); c = (n > 0) ? (b / (1 << (n - 1))) % 2 : 0; upd = 1; end
        11: begin s = sgn(b); r = (s >>> n) & 16'hFFFF;
              c = (n > 0) ? ((s >>> (n - 1)) & 1) : 0; upd = 1; end
        12: r = inport;
        13: begin e_outport = alu1; e_outvalid = 1; end
        15: begin e_halt = 1; e_wr = 0; e_mw = 0; end
        default: r = 0;
      endcase
      e_aluresult = 16'(r);
      if (upd) e_flags = {e_aluresult[15], e_aluresult == 16'd0, c[0], v[0]};
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".aluresult"}, aluresult, e_aluresult);
    chk({tag, ".writeregout"}, 16'(writeregout), 16'(e_wr));
    chk({tag, ".regaddressout"}, 16'(regaddressout), 16'(e_ra));
    chk({tag, ".memwriteout"}, 16'(memwriteout), 16'(e_mw));
    chk({tag, ".addressout"}, addressout, e_addr);
    chk({tag, ".storedataout"}, storedataout, e_sd);
    chk({tag, ".flags"}, 16'(flags), 16'(e_flags));
    chk({tag, ".branchtaken"}, 16'(branchtaken), 16'(e_bt));
    chk({tag, ".branchtarget"}, branchtarget, e_btgt);
    chk({tag, ".outport"}, outport, e_outport);
    chk({tag, ".outvalid"}, 16'(outvalid), 16'(e_outvalid));
    chk({tag, ".haltout"}, 16'(haltout), 16'(e_halt));
    chk({tag, ".fsmstate"}, 16'(fsmstate), 16'(e_halt));
  endtask

  // driver: key fields from the caller, the rest random
  task automatic set_insn(input logic [3:0] op, input logic imm, input logic [3:0] sh,
                          input logic [15:0] a1, input logic [15:0] a2, input logic br,
                          input logic [2:0] cnd, input logic [15:0] pc, input logic [15:0] adr);
    opcode = op; isimm = imm; shamt = sh; alu1 = a1; alu2 = a2; isbranch = br;
    cond = cnd; pcin = pc; address = adr; writereg = 1'b1;
    regaddress = 3'($urandom_range(0, 7)); memwrite = 2'($urandom_range(0, 2));
    storedata = 16'($urandom); inport = 16'($urandom);
  endtask

  // called at a negedge with inputs set; returns at the following negedge
  task automatic step(input string tag);
    model_step();
    @(posedge clockp3);
    #1;
    check_all(tag);
    @(negedge clockp3);
  endtask

  // called at a negedge; asynchronous assert, checked before any clock edge
  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'h0, 1'b0, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h8000, 4'b1001, 1'b0};
    tbl[1]  = '{4'h5, 1'b0, 4'h0, 16'h0005, 16'h0005, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0};
    tbl[2]  = '{4'h0, 1'b0, 4'h0, 16'h1111, 16'h2222, 1'b1, 3'd0, 16'h0010, 16'hFFFC, 16'h000C, 4'b0100, 1'b1};
    tbl[3]  = '{4'h1, 1'b1, 4'h0, 16'h0003, 16'h0005, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'hFFFE, 4'b1010, 1'b0};
    tbl[4]  = '{4'h1, 1'b0, 4'h0, 16'h0003, 16'h0005, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0002, 4'b0000, 1'b0};
    tbl[5]  = '{4'hB, 1'b0, 4'h1, 16'h0000, 16'h8001, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'hC000, 4'b1010, 1'b0};
    tbl[6]  = '{4'h8, 1'b0, 4'h1, 16'h0000, 16'h8001, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0002, 4'b0010, 1'b0};
    tbl[7]  = '{4'h9, 1'b0, 4'h4, 16'h0000, 16'h8001, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0018, 4'b0000, 1'b0};
    tbl[8]  = '{4'hA, 1'b0, 4'h0, 16'h0000, 16'h8001, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h8001, 4'b1000, 1'b0};
    tbl[9]  = '{4'h0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'h0100, 16'h0020, 16'h0120, 4'b1000, 1'b1};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 3'd5, 16'hFFFF, 16'h0002, 16'h0001, 4'b1000, 1'b0};
    tbl[11] = '{4'h2, 1'b0, 4'h0, 16'hFF0F, 16'h0FF0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0F00, 4'b0000, 1'b0};

    reset = 1'b1;
    set_insn(4'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
    @(negedge clockp3);
    do_reset();

    // table vectors
    for (int i = 0; i < 12; i++) begin
      set_insn(tbl[i].op, tbl[i].imm, tbl[i].sh, tbl[i].a1, tbl[i].a2, tbl[i].br,
               tbl[i].cnd, tbl[i].pc, tbl[i].adr);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.res", i), aluresult, tbl[i].exp_res);
      chk($sformatf("tbl%0d.flags", i), 16'(flags), 16'(tbl[i].exp_flags));
      chk($sformatf("tbl%0d.bt", i), 16'(branchtaken), 16'(tbl[i].exp_bt));
      chk($sformatf("tbl%0d.wr", i), 16'(writeregout), 16'(!tbl[i].br));
    end

    // OUT then ADD: one-cycle outvalid, outport holds
    set_insn(4'hD, 1'b0, 4'h0, 16'h1234, 16'h0007, 1'b0, 3'd0, 16'h0, 16'h0);
    step("out");
    chk("out.outport", outport, 16'h1234);
    chk("out.outvalid", 16'(outvalid), 16'd1);
    chk("out.result", aluresult, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      set_insn(4'h0, 1'b0, 4'h0, 16'h0001, 16'h0001, 1'b0, 3'd0, 16'h0, 16'h0);
      step("out_after");
      chk("out_after.outvalid", 16'(outvalid), 16'd0);
      chk("out_after.outport", outport, 16'h1234);
    end

    // HLT freezes everything; reset mid-halt recovers
    set_insn(4'hF, 1'b0, 4'h0, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0, 16'h0);
    memwrite = 2'b10;
    step("hlt");
    chk("hlt.haltout", 16'(haltout), 16'd1);
    chk("hlt.writeregout", 16'(writeregout), 16'd0);
    chk("hlt.memwriteout", 16'(memwriteout), 16'd0);
    for (int k = 0; k < 3; k++) begin
      set_insn(4'h0, 1'b0, 4'h0, 16'($urandom), 16'($urandom), 1'b0, 3'd0, 16'($urandom), 16'($urandom));
      step("halted");
      chk("halted.aluresult", aluresult, 16'h0000);
      chk("halted.haltout", 16'(haltout), 16'd1);
    end
    do_reset();
    set_insn(4'h0, 1'b0, 4'h0, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0, 16'h0);
    step("post_reset");
    chk("post_reset.aluresult", aluresult, 16'h0003);
    chk("post_reset.haltout", 16'(haltout), 16'd0);

    // randomized stimulus against the model
    for (int k = 0; k < 400; k++) begin
      logic [3:0] op;
      logic       br;
      br = ($urandom_range(0, 3) == 0);
      op = 4'($urandom_range(0, 14));
      set_insn(op, 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), br,
               3'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) alu2 = 16'($urandom_range(0, 3)) << 14;
      if ($urandom_range(0, 4) == 0) alu1 = alu2;
      writereg = 1'($urandom);
      step("rand");
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
